ahblite_slave_mux: RTL and testbench
====================================

Name: ahblite_slave_mux

Overview:
- Response side of the AHB-Lite interconnect; pairs with the system address decoder.
- Takes the five decoder HSEL lines and registers the selection at the address-phase boundary.
- In the data phase it routes the selected slave's HREADYOUT/HRESP/HRDATA back to the Cortex-M0 master.
- An integrated default slave gives the two-cycle AHB ERROR response to accesses hitting no mapped region, and counts them for debug.

Parameters:
- NPORT, 5, number of slave ports (P0 RAMCODE, P1 RAMDATA, P2 APB bridge, P3 UART, P4 GPIO); fixed at 5 in this revision.
- ERRCNT_W, 8, width of saturating unmapped-access counter.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HTRANS  input  2  master transfer type; bit1=1 means NONSEQ/SEQ.
- P_HSEL  input  5  decoder selects; bit k = port k.
- P_HREADYOUT  input  5  per-slave ready.
- P_HRESP  input  5  per-slave response (1=ERROR).
- P_HRDATA  input  160  per-slave read data; port k at [32k+31:32k].
- ERR_CLR  input  1  synchronous clear of ERR_CNT.
- HREADY  output  1  muxed ready to master; also fanned back to all slaves.
- HRESP  output  1  muxed response.
- HRDATA  output  32  muxed read data.
- ERR_CNT  output  ERRCNT_W  unmapped active transfers seen, saturating.

Behaviour:
- Data-phase select register sel_q (one-hot, 5 ports + "none") loads only when HREADY=1.
- Load value when HREADY=1: lowest-indexed set bit of P_HSEL. Multiple bits set: lowest index wins, no error raised.
- P_HSEL=0 loads "none".
- HREADY=0: sel_q holds.
- sel_q = port k: HREADY=P_HREADYOUT[k], HRESP=P_HRESP[k], HRDATA=P_HRDATA[32k+31:32k]. Purely combinational from sel_q; zero added latency.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 when HREADY=1, HTRANS[1]=1 and P_HSEL=0.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if the same unmapped condition holds (back-to-back errors); else -> IDLE.
- Default-slave outputs, driven when sel_q="none":
  - IDLE: HREADY=1, HRESP=0 (OKAY).
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
  - HRDATA=32'h0 in all states.
- Unmapped IDLE/BUSY transfers (HTRANS[1]=0): zero-wait OKAY; FSM stays IDLE.
- Master may drive HTRANS=IDLE during ERR1 (cancel of following transfer). That address is sampled in ERR2 with HREADY=1 and takes the IDLE path normally.
- ERR_CNT:
  - Increments by 1 on each IDLE/ERR2 -> ERR1 transition.
  - Saturates at 2^ERRCNT_W-1 (255).
  - ERR_CLR=1 zeroes it next cycle; clear wins over a simultaneous increment.
- Reset values (HRESET=1, next edge): sel_q="none", FSM=IDLE, ERR_CNT=0.
  - Outputs after reset: HREADY=1, HRESP=0, HRDATA=0.
  - Reset mid-wait (a slave stalling or FSM in ERR1) abandons the transfer and returns to these values on the next cycle.
- No combinational path from HTRANS/P_HSEL to HREADY/HRESP/HRDATA (address→data-phase separation).

Test Plan:
- Reset: hold HRESET 2 cycles, P_HREADYOUT=0 -> HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0.
- Mapped read: P_HSEL=5'b00010, HTRANS=2'b10; next cycle P_HRDATA port1=32'hDEADBEEF, P_HREADYOUT[1]=0 then 1 -> HREADY 0 then 1; HRDATA=32'hDEADBEEF on completion; sel_q held during stall.
- Unmapped NONSEQ (address 0x60000000, P_HSEL=0): next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then HREADY=1/HRESP=0; ERR_CNT=1.
- Back-to-back unmapped NONSEQ presented in ERR2 -> ERR1,ERR2,ERR1,ERR2 sequence, ERR_CNT=2. Unmapped HTRANS=IDLE -> single-cycle OKAY, ERR_CNT unchanged.
- Saturation/clear: 300 unmapped NONSEQ -> ERR_CNT=255. ERR_CLR=1 coincident with a new ERR1 entry -> ERR_CNT=0.
- Priority/reset-mid-op: P_HSEL=5'b10100 -> port2 data routed. Assert HRESET during ERR1 -> next cycle HREADY=1, HRESP=0, FSM IDLE.

Source files
------------

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response-side mux: registers the decoder select at the address-phase
// boundary and returns the selected slave's ready/resp/rdata. Unmapped transfers go to a built-in default slave.

module ahblite_slave_mux_lane (
    input  logic        sel,
    input  logic        readyout,
    input  logic        resp,
    input  logic [31:0] rdata,
    output logic        lane_ready,
    output logic        lane_resp,
    output logic [31:0] lane_rdata
);

    assign lane_ready = sel & readyout;
    assign lane_resp  = sel & resp;
    assign lane_rdata = {32{sel}} & rdata;

endmodule

module ahblite_slave_mux #(
    parameter int NPORT    = 5,
    parameter int ERRCNT_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [1:0]            HTRANS,
    input  logic [NPORT-1:0]      P_HSEL,
    input  logic [NPORT-1:0]      P_HREADYOUT,
    input  logic [NPORT-1:0]      P_HRESP,
    input  logic [NPORT*32-1:0]   P_HRDATA,
    input  logic                  ERR_CLR,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ERRCNT_W-1:0]   ERR_CNT
);

    localparam int NONE = NPORT;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic [NPORT:0]              sel_q;
    logic [NPORT:0]              sel_d;
    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic [ERRCNT_W-1:0]         err_cnt_q;

    logic [NPORT-1:0]            lane_ready;
    logic [NPORT-1:0]            lane_resp;
    logic [NPORT-1:0][31:0]      lane_rdata;
    logic [31:0]                 rdata_or;

    logic                        def_ready;
    logic                        def_resp;
    logic                        unmapped;
    logic                        err_entry;
    logic                        htrans_unused;

    assign htrans_unused = HTRANS[0];

    // Lowest-indexed select wins; no select at all routes to the default slave.
    always_comb begin
        sel_d       = '0;
        sel_d[NONE] = 1'b1;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (P_HSEL[k]) begin
                sel_d    = '0;
                sel_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q       <= '0;
            sel_q[NONE] <= 1'b1;
        end else if (HREADY) begin
            sel_q <= sel_d;
        end
    end

    for (genvar k = 0; k < NPORT; k++) begin : g_lane
        ahblite_slave_mux_lane u_lane (
            .sel        (sel_q[k]),
            .readyout   (P_HREADYOUT[k]),
            .resp       (P_HRESP[k]),
            .rdata      (P_HRDATA[32*k +: 32]),
            .lane_ready (lane_ready[k]),
            .lane_resp  (lane_resp[k]),
            .lane_rdata (lane_rdata[k])
        );
    end

    always_comb begin
        rdata_or = '0;
        for (int k = 0; k < NPORT; k++) begin
            rdata_or = rdata_or | lane_rdata[k];
        end
    end

    // Two-cycle ERROR: first cycle stalls, second completes with resp held.
    assign def_ready = (state_q != ST_ERR1);
    assign def_resp  = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    assign HREADY = (|lane_ready) | (sel_q[NONE] & def_ready);
    assign HRESP  = (|lane_resp)  | (sel_q[NONE] & def_resp);
    assign HRDATA = rdata_or;

    assign unmapped = HREADY & HTRANS[1] & ~(|P_HSEL);

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = unmapped ? ST_ERR1 : ST_IDLE;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = unmapped ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_entry = (state_d == ST_ERR1) && (state_q != ST_ERR1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear takes priority over a same-cycle increment; count sticks at all-ones.
    always_ff @(posedge HCLK) begin
        if (HRESET || ERR_CLR) begin
            err_cnt_q <= '0;
        end else if (err_entry && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux: stimulus pushes per-cycle expected
// responses, a negedge monitor pops and compares them.

module tb_ahblite_slave_mux;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [1:0]    HTRANS;
    logic [4:0]    P_HSEL;
    logic [4:0]    P_HREADYOUT;
    logic [4:0]    P_HRESP;
    logic [159:0]  P_HRDATA;
    logic          ERR_CLR;
    logic          HREADY;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [7:0]    ERR_CNT;

    always #5 HCLK = ~HCLK;

    ahblite_slave_mux #(.NPORT(5), .ERRCNT_W(8)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HTRANS      (HTRANS),
        .P_HSEL      (P_HSEL),
        .P_HREADYOUT (P_HREADYOUT),
        .P_HRESP     (P_HRESP),
        .P_HRDATA    (P_HRDATA),
        .ERR_CLR     (ERR_CLR),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA),
        .ERR_CNT     (ERR_CNT)
    );

    typedef struct {
        string       name;
        logic        rdy;
        logic        rsp;
        logic [31:0] rd;
        bit          chk_rd;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    task automatic expect_cyc(input string nm, input logic rdy, input logic rsp,
                              input logic [31:0] rd, input bit chk_rd, input logic [7:0] cnt);
        exp_t e;
        e.name   = nm;
        e.rdy    = rdy;
        e.rsp    = rsp;
        e.rd     = rd;
        e.chk_rd = chk_rd;
        e.cnt    = cnt;
        sb.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_data(input int k, input logic [31:0] d);
        P_HRDATA[32*k +: 32] = d;
    endtask

    // Monitor: compares whatever expectation is pending for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "hready", {31'b0, HREADY}, {31'b0, e.rdy});
                cmp(e.name, "hresp",  {31'b0, HRESP},  {31'b0, e.rsp});
                if (e.chk_rd) cmp(e.name, "hrdata", HRDATA, e.rd);
                cmp(e.name, "err_cnt", {24'b0, ERR_CNT}, {24'b0, e.cnt});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; HTRANS = 2'b00; P_HSEL = '0; P_HREADYOUT = '0;
        P_HRESP = '0; ERR_CLR = 1'b0; P_HRDATA = '0;
        for (int k = 0; k < 5; k++) set_data(k, 32'h1111_1111 * (k + 1));
        next_cyc();
        next_cyc();

        // Reset state, with stalling slaves and nonzero data on every port
        HRESET = 1'b0;
        expect_cyc("reset", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();

        // Mapped read on port1 with one wait state; port2 address held during the stall
        P_HSEL = 5'b00010; HTRANS = 2'b10; P_HREADYOUT = '1;
        expect_cyc("rd_addr", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();
        P_HSEL = 5'b00100; set_data(1, 32'hDEADBEEF); set_data(2, 32'h2222_2222);
        P_HREADYOUT = 5'b11101;
        expect_cyc("rd_stall", 0, 0, 32'h0, 0, 8'd0);
        next_cyc();
        P_HREADYOUT = '1;
        expect_cyc("rd_done", 1, 0, 32'hDEADBEEF, 1, 8'd0);
        next_cyc();
        P_HSEL = '0; HTRANS = 2'b00;
        expect_cyc("rd_port2", 1, 0, 32'h2222_2222, 1, 8'd0);
        next_cyc();

        // Single unmapped NONSEQ, master cancels with IDLE during ERR1
        HTRANS = 2'b10;
        expect_cyc("unm_addr", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();
        HTRANS = 2'b00;
        expect_cyc("unm_err1", 0, 1, 32'h0, 1, 8'd1);
        next_cyc();
        expect_cyc("unm_err2", 1, 1, 32'h0, 1, 8'd1);
        next_cyc();
        expect_cyc("unm_okay", 1, 0, 32'h0, 1, 8'd1);
        next_cyc();

        // Back-to-back unmapped NONSEQ
        HTRANS = 2'b10;
        expect_cyc("b2b_addr", 1, 0, 32'h0, 1, 8'd1);
        next_cyc();
        expect_cyc("b2b_err1a", 0, 1, 32'h0, 1, 8'd2);
        next_cyc();
        expect_cyc("b2b_err2a", 1, 1, 32'h0, 1, 8'd2);
        next_cyc();
        HTRANS = 2'b00;
        expect_cyc("b2b_err1b", 0, 1, 32'h0, 1, 8'd3);
        next_cyc();
        expect_cyc("b2b_err2b", 1, 1, 32'h0, 1, 8'd3);
        next_cyc();

        // Unmapped BUSY/IDLE complete as zero-wait OKAY
        HTRANS = 2'b01;
        expect_cyc("busy_okay", 1, 0, 32'h0, 1, 8'd3);
        next_cyc();
        HTRANS = 2'b00;
        expect_cyc("idle_okay", 1, 0, 32'h0, 1, 8'd3);
        next_cyc();

        ERR_CLR = 1'b1;
        expect_cyc("clr", 1, 0, 32'h0, 1, 8'd3);
        next_cyc();
        ERR_CLR = 1'b0;
        expect_cyc("clr_done", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();

        // 300 back-to-back unmapped NONSEQ: ERR1 entries at even cycles 0..598
        HTRANS = 2'b10;
        repeat (599) next_cyc();
        HTRANS = 2'b00;
        expect_cyc("sat_err1", 0, 1, 32'h0, 1, 8'd255);
        next_cyc();
        expect_cyc("sat_err2", 1, 1, 32'h0, 1, 8'd255);
        next_cyc();
        expect_cyc("sat_idle", 1, 0, 32'h0, 1, 8'd255);
        next_cyc();

        // Clear coincident with a new ERR1 entry
        HTRANS = 2'b10; ERR_CLR = 1'b1;
        expect_cyc("clr_vs_inc", 1, 0, 32'h0, 1, 8'd255);
        next_cyc();
        HTRANS = 2'b00; ERR_CLR = 1'b0;
        expect_cyc("clr_err1", 0, 1, 32'h0, 1, 8'd0);
        next_cyc();
        expect_cyc("clr_err2", 1, 1, 32'h0, 1, 8'd0);
        next_cyc();

        // Multiple selects: port2 beats port4; slave ERROR resp is routed
        P_HSEL = 5'b10100; HTRANS = 2'b10; set_data(4, 32'h4444_4444);
        expect_cyc("prio_addr", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();
        P_HSEL = '0; HTRANS = 2'b00; P_HRESP = 5'b10100;
        expect_cyc("prio_data", 1, 1, 32'h2222_2222, 1, 8'd0);
        next_cyc();

        // Pipelined sweep over all ports
        P_HRESP = '0;
        for (int k = 0; k < 5; k++) begin
            P_HSEL = 5'b00001 << k; HTRANS = 2'b10;
            set_data(k, 32'hC0DE_0000 | k);
            if (k == 0) expect_cyc("sweep0", 1, 0, 32'h0, 1, 8'd0);
            else        expect_cyc($sformatf("sweep%0d", k), 1, 0, 32'hC0DE_0000 | (k - 1), 1, 8'd0);
            next_cyc();
        end
        P_HSEL = '0; HTRANS = 2'b00;
        expect_cyc("sweep5", 1, 0, 32'hC0DE_0004, 1, 8'd0);
        next_cyc();

        // Reset during ERR1
        HTRANS = 2'b10;
        expect_cyc("rst_addr", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();
        HRESET = 1'b1; HTRANS = 2'b00;
        expect_cyc("rst_err1", 0, 1, 32'h0, 1, 8'd1);
        next_cyc();
        HRESET = 1'b0;
        expect_cyc("rst_after", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();

        // Reset during a slave stall
        P_HSEL = 5'b00001; HTRANS = 2'b10;
        expect_cyc("rst2_addr", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();
        P_HSEL = '0; HTRANS = 2'b00; P_HREADYOUT = '0; HRESET = 1'b1;
        expect_cyc("rst2_stall", 0, 0, 32'h0, 0, 8'd0);
        next_cyc();
        HRESET = 1'b0;
        expect_cyc("rst2_after", 1, 0, 32'h0, 1, 8'd0);
        next_cyc();

        repeat (3) next_cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
